// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller on the CPU data bus.
// Software writes a 16-bit hex value (DATA) and control bits (CTRL). The
// digits are lit one at a time, with an all-off gap between them so the
// previous digit does not ghost. DATA and the mask/dp bits are copied into
// shadow registers once per frame, so the display never shows half an update.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,  // cycles each digit is lit (>= 2)
   parameter int BLANK_CYCLES = 100     // all-off cycles between digits (1 .. SCAN_DIV-1)
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   // BLANK_CYCLES < SCAN_DIV, so one counter sized for SCAN_DIV serves both phases
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;

   logic [15:0]   data_q;
   logic [8:0]    ctrl_q;
   logic [15:0]   shadow_data;
   logic [3:0]    shadow_mask;
   logic [3:0]    shadow_dp;
   logic          pending;
   logic [1:0]    state;
   logic [1:0]    digit;
   logic [CW-1:0] presc;

   logic          wr_data;
   logic          wr_ctrl;
   logic          en_next;
   logic          shadow_load;
   logic [3:0]    nibble;
   logic [6:0]    pattern;

   // Only the low bits of the write bus carry register fields
   logic unused_bits;
   assign unused_bits = ^data_i[31:16];

   assign wr_data = ce_i && we_i && (addr_i == ADDR_DATA);
   assign wr_ctrl = ce_i && we_i && (addr_i == ADDR_CTRL);

   // The global enable bypasses the shadow: a write clearing it blanks the
   // display at that very edge rather than one cycle later.
   assign en_next = wr_ctrl ? data_i[8] : ctrl_q[8];

   // First BLANK cycle ahead of digit 0 is the frame boundary
   assign shadow_load = (state == ST_BLANK) && (digit == 2'd0) && (presc == '0);

   assign nibble = shadow_data[4*digit +: 4];

   // Active-low gfedcba pattern for one hex nibble
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign pattern = hex7(nibble);

   // Software-visible DATA and CTRL registers
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         if (wr_data) data_q <= data_i[15:0];
         if (wr_ctrl) ctrl_q <= data_i[8:0];
      end
   end

   // Frame-boundary shadow copy; a write on the load edge keeps pending set
   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         shadow_data <= '0;
         shadow_mask <= '0;
         shadow_dp   <= '0;
         pending     <= 1'b0;
      end else begin
         if (shadow_load) begin
            shadow_data <= data_q;
            shadow_mask <= ctrl_q[3:0];
            shadow_dp   <= ctrl_q[7:4];
         end
         if (wr_data || wr_ctrl) pending <= 1'b1;
         else if (shadow_load)   pending <= 1'b0;
      end
   end

   // Scan sequencer: OFF -> BLANK -> SHOW -> BLANK ... with digit rotation
   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         state <= ST_OFF;
         digit <= 2'd0;
         presc <= '0;
      end else if (!en_next) begin
         state <= ST_OFF;
         digit <= 2'd0;
         presc <= '0;
      end else begin
         case (state)
            ST_OFF: begin
               state <= ST_BLANK;
               digit <= 2'd0;
               presc <= '0;
            end
            ST_BLANK: begin
               if (presc == BLANK_LAST) begin
                  state <= ST_SHOW;
                  presc <= '0;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            ST_SHOW: begin
               if (presc == SCAN_LAST) begin
                  state <= ST_BLANK;
                  presc <= '0;
                  digit <= digit + 2'd1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: begin
               state <= ST_OFF;
               digit <= 2'd0;
               presc <= '0;
            end
         endcase
      end
   end

   // Registered pin drivers: follow the sequencer one cycle later, blank at once on disable
   always_ff @(posedge clk_100mhz or negedge rst) begin
      if (!rst) begin
         seg <= 8'hFF;
         an  <= 4'hF;
      end else if (!en_next || (state != ST_SHOW)) begin
         seg <= 8'hFF;
         an  <= 4'hF;
      end else begin
         seg <= {~shadow_dp[digit], pattern};
         an  <= shadow_mask[digit] ? ~(4'b0001 << digit) : 4'hF;
      end
   end

   // Bus read mux; reads as zero when the block is not selected
   // NOTE: default assignment first so no path through the block infers a latch.
   always_comb begin
      data_o = '0;
      if (ce_i) begin
         case (addr_i)
            ADDR_DATA:   data_o[15:0] = data_q;
            ADDR_CTRL:   data_o[8:0]  = ctrl_q;
            ADDR_STATUS: data_o[3:0]  = {pending, (state == ST_SHOW), digit};
            default:     data_o       = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
// Expected {an,seg} per cycle are queued when a scan is started and compared
// by a negedge monitor; register reads and spot checks use the same task.
module tb_seg7_scan_ctrl;

   localparam int SCAN = 8;
   localparam int BLK  = 2;
   localparam logic [11:0] BLANK_V = 12'hFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  seg;
   logic [3:0]  an;

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] sb_q[$];
   string       sb_tag = "idle";

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYCLES(BLK)) dut (
      .clk_100mhz (clk),
      .rst        (rst),
      .ce_i       (ce),
      .we_i       (we),
      .addr_i     (addr),
      .data_i     (wdata),
      .data_o     (rdata),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Expected {an,seg} while digit d is lit
   function automatic logic [11:0] lit_v(input int d, input logic [15:0] dat, input logic [8:0] ctl);
      logic [3:0] one;
      logic [3:0] nib;
      logic [3:0] a;
      one = 4'b0001;
      nib = dat[4*d +: 4];
      a   = ctl[d] ? ~(one << d) : 4'hF;
      return {a, ~ctl[4+d], hex_tab[nib]};
   endfunction

   task automatic push_slot(input int d, input logic [15:0] dat, input logic [8:0] ctl, input int nlit);
      for (int i = 0; i < BLK; i++) sb_q.push_back(BLANK_V);
      for (int i = 0; i < nlit; i++) sb_q.push_back(lit_v(d, dat, ctl));
   endtask

   task automatic push_frame(input logic [15:0] dat, input logic [8:0] ctl);
      for (int d = 0; d < 4; d++) push_slot(d, dat, ctl, SCAN);
   endtask

   task automatic push_blanks(input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(BLANK_V);
   endtask

   // Write lands on the posedge; returns 1 time unit after it
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      ce = 1'b0; we = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = a;
      #1;
      check(tag, rdata, exp);
      ce = 1'b0;
   endtask

   // Enable scanning from OFF and queue the expected outputs from the write edge on
   task automatic start_scan(input logic [8:0] ctl, input logic [15:0] dat, input int frames);
      bus_write(2'd1, {23'd0, ctl});
      sb_q.push_back(BLANK_V);
      for (int f = 0; f < frames; f++) push_frame(dat, ctl);
   endtask

   task automatic wait_drain(input int budget);
      for (int c = 0; c < budget && sb_q.size() > 0; c++) @(posedge clk);
      check("drain", sb_q.size(), 0);
   endtask

   // Cycles between two successive rising edges into digit 0 (an F -> E)
   task automatic measure_period(output int period);
      int t_first;
      logic [3:0] prev;
      t_first = -1;
      period  = -1;
      prev    = an;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (prev == 4'hF && an == 4'hE) begin
            if (t_first < 0) t_first = c;
            else begin
               period = c - t_first;
               break;
            end
         end
         prev = an;
      end
   endtask

   // Scoreboard monitor: one expected {an,seg} per cycle while the queue holds entries
   always @(negedge clk) begin
      logic [11:0] exp;
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check(sb_tag, {20'd0, an, seg}, {20'd0, exp});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached with %0d checks done, expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      int period;
      rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_seg", {24'd0, seg}, 32'hFF);
      check("rst_an", {28'd0, an}, 32'hF);
      ce = 1'b1;
      for (int a = 0; a < 4; a++) begin
         addr = a[1:0];
         #1;
         check($sformatf("rst_rd%0d", a), rdata, 32'd0);
      end
      ce = 1'b0;
      #1;
      check("rd_ce0", rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      sb_tag = "idle_blank";
      push_blanks(100);
      wait_drain(200);

      // Register access: upper bits dropped, STATUS and addr 3 writes ignored
      bus_write(2'd0, 32'hDEAD_1A3F);
      read_check("rd_data", 2'd0, 32'h0000_1A3F);
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_write(2'd2, 32'hFFFF_FFFF);
      read_check("rd_data_kept", 2'd0, 32'h0000_1A3F);
      read_check("rd_addr3", 2'd3, 32'd0);
      read_check("rd_status_pend", 2'd2, 32'h8);

      // Basic scan, two frames, then frame period
      sb_tag = "basic";
      start_scan(9'h10F, 16'h1A3F, 2);
      read_check("rd_ctrl", 2'd1, 32'h10F);
      wait_drain(200);
      measure_period(period);
      check("frame_period", period, 4 * (SCAN + BLK));

      // Digit mask and decimal points
      bus_write(2'd1, 32'h0);
      bus_write(2'd0, 32'h8888);
      sb_tag = "mask_125";
      start_scan(9'h125, 16'h8888, 1);
      wait_drain(200);
      bus_write(2'd1, 32'h0);
      sb_tag = "mask_115";
      start_scan(9'h115, 16'h8888, 1);
      wait_drain(200);

      // Tear-free update while digit 2 is lit
      bus_write(2'd1, 32'h0);
      bus_write(2'd0, 32'h8888);
      sb_tag = "tear";
      start_scan(9'h10F, 16'h8888, 1);
      push_frame(16'hFFFF, 9'h10F);
      repeat (23) @(posedge clk);
      read_check("st_show_d2", 2'd2, 32'h6);
      bus_write(2'd0, 32'h0000);
      bus_write(2'd0, 32'hFFFF);
      repeat (14) @(posedge clk);
      read_check("st_pend_blank", 2'd2, 32'h8);
      read_check("st_pend_clear", 2'd2, 32'h0);
      wait_drain(200);

      // Disable during digit 1, then restart from digit 0
      bus_write(2'd1, 32'h0);
      bus_write(2'd0, 32'h1A3F);
      sb_tag = "disable";
      bus_write(2'd1, 32'h10F);
      sb_q.push_back(BLANK_V);
      push_slot(0, 16'h1A3F, 9'h10F, SCAN);
      push_slot(1, 16'h1A3F, 9'h10F, 2);
      push_blanks(10);
      repeat (14) @(posedge clk);
      bus_write(2'd1, 32'h00F);
      read_check("st_off", 2'd2, 32'h8);
      wait_drain(100);
      sb_tag = "reenable";
      start_scan(9'h10F, 16'h1A3F, 1);
      wait_drain(200);

      // Asynchronous reset while digit 3 is lit
      bus_write(2'd1, 32'h0);
      sb_tag = "pre_reset";
      bus_write(2'd1, 32'h10F);
      sb_q.push_back(BLANK_V);
      for (int d = 0; d < 3; d++) push_slot(d, 16'h1A3F, 9'h10F, SCAN);
      push_slot(3, 16'h1A3F, 9'h10F, 2);
      repeat (35) @(posedge clk);
      #1;
      check("d3_lit", {20'd0, an, seg}, {20'd0, lit_v(3, 16'h1A3F, 9'h10F)});
      #1;
      rst = 1'b0;
      #1;
      check("async_an", {28'd0, an}, 32'hF);
      check("async_seg", {24'd0, seg}, 32'hFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      read_check("post_rst_data", 2'd0, 32'd0);
      read_check("post_rst_ctrl", 2'd1, 32'd0);
      read_check("post_rst_status", 2'd2, 32'd0);
      sb_tag = "post_rst_blank";
      #1;
      push_blanks(20);
      wait_drain(100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
